// File: rtl/fp32_pkg.sv
// Shared FP32 format constants, flag positions and enums for the FP arithmetic datapath.
package fp32_pkg;
   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;
   localparam int FRAC_W   = 23;
   localparam int MANT_W   = 24;
   localparam int DIV_ITER = 26;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   // flags = {invalid, div_by_zero, overflow, underflow}
   localparam int FLAG_INV = 3;
   localparam int FLAG_DBZ = 2;
   localparam int FLAG_OVF = 1;
   localparam int FLAG_UNF = 0;

   typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} div_state_t;
   typedef enum logic [1:0] {NORMAL, ZERO, INF, NAN} fp_class_t;

   function automatic logic [31:0] fp_inf(input logic s);
      return {s, 8'(EXP_MAX), {FRAC_W{1'b0}}};
   endfunction

   function automatic logic [31:0] fp_zero(input logic s);
      return {s, 31'h0};
   endfunction
endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier; denormals are reported as ZERO (flush-to-zero).
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [7:0]        exp,
   input  logic [FRAC_W-1:0] frac,
   output fp_class_t         cls
);
   always_comb begin
      cls = NORMAL;
      if (exp == 8'd0)
         cls = ZERO;
      else if (exp == 8'(EXP_MAX))
         cls = (frac == '0) ? INF : NAN;
   end
endmodule

// File: rtl/fp32_div_seq.sv
// Sequential FP32 divider: restoring radix-2 mantissa division (one quotient bit per clock),
// then a single normalise/round cycle. Fixed 27-cycle latency from accept to out_valid.
module fp32_div_seq
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] F,
   output logic [3:0]  flags
);
   localparam logic signed [9:0] E_MAX_S = 10'(EXP_MAX);

   div_state_t            state;
   logic                  sign_r;
   logic signed [9:0]     exp_r;
   logic [MANT_W:0]       rem;
   logic [MANT_W-1:0]     mb;
   logic [DIV_ITER-1:0]   q;
   logic [4:0]            cnt;
   logic                  spec_r;
   logic [31:0]           spec_f;
   logic [3:0]            spec_flags;

   fp_class_t ca, cb;

   fp32_classify u_cls_a (.exp(A[30:23]), .frac(A[FRAC_W-1:0]), .cls(ca));
   fp32_classify u_cls_b (.exp(B[30:23]), .frac(B[FRAC_W-1:0]), .cls(cb));

   assign in_ready = (state == IDLE);

   // Special-case result is resolved at accept; the datapath still runs so latency is uniform.
   logic              s_in;
   logic              sp_hit;
   logic [31:0]       sp_f;
   logic [3:0]        sp_flags;
   logic signed [9:0] e_in;

   always_comb begin
      s_in     = A[31] ^ B[31];
      e_in     = $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'(EXP_BIAS);
      sp_hit   = 1'b1;
      sp_f     = '0;
      sp_flags = '0;
      if (ca == NAN || cb == NAN)
         sp_f = QNAN;
      else if ((ca == ZERO && cb == ZERO) || (ca == INF && cb == INF)) begin
         sp_f               = QNAN;
         sp_flags[FLAG_INV] = 1'b1;
      end else if (ca == INF)
         sp_f = fp_inf(s_in);
      else if (cb == ZERO) begin
         sp_f               = fp_inf(s_in);
         sp_flags[FLAG_DBZ] = 1'b1;
      end else if (ca == ZERO || cb == INF)
         sp_f = fp_zero(s_in);
      else
         sp_hit = 1'b0;
   end

   logic              rem_ge;
   logic [MANT_W:0]   rem_sub;

   always_comb begin
      rem_ge  = rem >= {1'b0, mb};
      rem_sub = rem_ge ? rem - {1'b0, mb} : rem;
   end

   logic [MANT_W-1:0] mant;
   logic              guard, sticky, rnd_up, rnd_carry;
   logic signed [9:0] e_norm, e_fin;
   logic [FRAC_W-1:0] frac_fin;

   // Quotient lies in (0.5, 2): q[25] selects which window holds the 24-bit mantissa.
   always_comb begin
      if (q[DIV_ITER-1]) begin
         mant   = q[25:2];
         guard  = q[1];
         sticky = q[0] | (|rem);
         e_norm = exp_r;
      end else begin
         mant   = q[24:1];
         guard  = q[0];
         sticky = |rem;
         e_norm = exp_r - 10'sd1;
      end
      rnd_up    = guard & (sticky | mant[0]);
      rnd_carry = rnd_up & (&mant);
      e_fin     = e_norm + $signed({9'd0, rnd_carry});
      frac_fin  = mant[FRAC_W-1:0] + FRAC_W'(rnd_up);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         F          <= '0;
         flags      <= '0;
         out_valid  <= 1'b0;
         sign_r     <= 1'b0;
         exp_r      <= '0;
         rem        <= '0;
         mb         <= '0;
         q          <= '0;
         cnt        <= '0;
         spec_r     <= 1'b0;
         spec_f     <= '0;
         spec_flags <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sign_r     <= s_in;
               exp_r      <= e_in;
               rem        <= {1'b0, 1'b1, A[FRAC_W-1:0]};
               mb         <= {1'b1, B[FRAC_W-1:0]};
               q          <= '0;
               cnt        <= '0;
               spec_r     <= sp_hit;
               spec_f     <= sp_f;
               spec_flags <= sp_flags;
               state      <= DIVIDE;
            end
            DIVIDE: begin
               q   <= {q[DIV_ITER-2:0], rem_ge};
               rem <= rem_sub << 1;
               cnt <= cnt + 5'd1;
               if (cnt == 5'(DIV_ITER - 1))
                  state <= ROUND;
            end
            ROUND: begin
               out_valid <= 1'b1;
               state     <= DONE;
               if (spec_r) begin
                  F     <= spec_f;
                  flags <= spec_flags;
               end else if (e_fin >= E_MAX_S) begin
                  F     <= fp_inf(sign_r);
                  flags <= 4'(1 << FLAG_OVF);
               end else if (e_fin <= 10'sd0) begin
                  F     <= fp_zero(sign_r);
                  flags <= 4'(1 << FLAG_UNF);
               end else begin
                  F     <= {sign_r, e_fin[7:0], frac_fin};
                  flags <= '0;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp32_div_seq.sv
// Scoreboard bench for fp32_div_seq: driver pushes model results, monitor pops on out_valid.
module tb_fp32_div_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] F;
   logic [3:0]  flags;

   fp32_div_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .F(F), .flags(flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] f;
      logic [3:0]  fl;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   hold_req = 0;
   bit   seen = 0;
   logic [31:0] hold_f;
   logic [3:0]  hold_fl;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: exact integer quotient of the significands, then generic round-to-nearest-even.
   function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      int ea, eb, e, p, sh;
      logic s, az, bz, ai, bi, an, bn;
      longint unsigned ma, mb, qq, rr, mant, rb, half;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      az = (ea == 0);
      bz = (eb == 0);
      ai = (ea == 255) && (a[22:0] == 0);
      bi = (eb == 255) && (b[22:0] == 0);
      an = (ea == 255) && (a[22:0] != 0);
      bn = (eb == 255) && (b[22:0] != 0);
      if (an || bn) return {4'b0000, 32'h7FC00000};
      if ((az && bz) || (ai && bi)) return {4'b1000, 32'h7FC00000};
      if (ai) return {4'b0000, s, 8'hFF, 23'h0};
      if (bz) return {4'b0100, s, 8'hFF, 23'h0};
      if (az || bi) return {4'b0000, s, 31'h0};
      ma = 64'(a[22:0]) | (64'd1 << 23);
      mb = 64'(b[22:0]) | (64'd1 << 23);
      qq = (ma << 30) / mb;
      rr = (ma << 30) % mb;
      p  = 0;
      for (int i = 62; i >= 0; i--)
         if (qq[i] && p == 0) p = i;
      sh   = p - 23;
      mant = qq >> sh;
      rb   = qq & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rb > half || (rb == half && (rr != 0 || mant[0]))) mant++;
      e = ea - eb + 127 + p - 30;
      if (mant == (64'd1 << 24)) begin
         mant = mant >> 1;
         e++;
      end
      if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
      if (e <= 0) return {4'b0001, s, 31'h0};
      return {4'b0000, s, 8'(e), mant[22:0]};
   endfunction

   // Monitor: one pop per result, then stability checks while it is held.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst)
            seen = 0;
         else if (out_valid && !seen) begin
            seen    = 1;
            hold_f  = F;
            hold_fl = flags;
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result: got F=%h flags=%h with nothing expected", F, flags);
            end else begin
               e = sb.pop_front();
               chk("F", F, e.f);
               chk("flags", 32'(flags), 32'(e.fl));
               chk("latency", 32'(cyc - e.acc), 32'd27);
            end
         end else if (out_valid && seen) begin
            chk("hold_F", F, hold_f);
            chk("hold_flags", 32'(flags), 32'(hold_fl));
            chk("busy_in_ready", 32'(in_ready), 32'd0);
         end else if (!out_valid && seen) begin
            seen = 0;
            chk("idle_after_accept", 32'(in_ready), 32'd1);
            chk("F_kept", F, hold_f);
         end
      end
   end

   // Consumer: accept each result hold_req cycles after it appears.
   initial begin
      int wcnt = 0;
      forever begin
         @(negedge clk);
         if (out_ready) begin
            out_ready = 1'b0;
            wcnt      = 0;
         end else if (out_valid && !rst) begin
            if (wcnt >= hold_req) out_ready = 1'b1;
            else wcnt++;
         end
      end
   end

   task automatic wait_ready(output bit ok);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      ok = in_ready;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 500 cycles");
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      bit ok;
      logic [35:0] r;
      wait_ready(ok);
      if (!ok) return;
      A = a;
      B = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      r = ref_div(a, b);
      sb.push_back('{r[31:0], r[35:32], cyc});
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || out_valid) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   function automatic logic [31:0] rand_fp();
      int sel;
      logic [31:0] x;
      sel = $urandom_range(0, 15);
      x   = $urandom;
      case (sel)
         0: x[30:0] = 31'h0;
         1: x[30:0] = {8'hFF, 23'h0};
         2: x[30:23] = 8'hFF;
         3, 4, 5: x[30:23] = 8'($urandom_range(1, 254));
         6: x[22:0] = 23'h7FFFFF;
         default: x[30:23] = 8'($urandom_range(100, 154));
      endcase
      return x;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      repeat (3) @(negedge clk);
      chk("reset_F", F, 32'h0);
      chk("reset_flags", 32'(flags), 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_in_ready", 32'(in_ready), 32'h1);
      rst = 1'b0;

      hold_req = 0;
      issue(32'h40C00000, 32'h40000000);
      drain();
      hold_req = 10;
      issue(32'h3F800000, 32'h40400000);
      drain();
      hold_req = 0;
      issue(32'hBF800000, 32'h40800000);
      issue(32'h3F800000, 32'h00000000);
      issue(32'h00000000, 32'h00000000);
      issue(32'h7F800000, 32'h7F800000);
      issue(32'h7F7FFFFF, 32'h3F000000);
      issue(32'h00800000, 32'h40000000);

      // Operands offered mid-DIVIDE must be ignored.
      issue(32'h41200000, 32'h40A00000);
      repeat (8) @(negedge clk);
      A = 32'h42C80000;
      B = 32'h3F800000;
      in_valid = 1'b1;
      chk("mid_divide_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      // Reset at iteration 12 abandons the operation.
      wait_ready(ok);
      if (ok) begin
         A = 32'h40490FDB;
         B = 32'h3FB504F3;
         in_valid = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
         repeat (12) @(posedge clk);
         #2 rst = 1'b1;
         #1;
         chk("rst_out_valid", 32'(out_valid), 32'h0);
         chk("rst_F", F, 32'h0);
         chk("rst_in_ready", 32'(in_ready), 32'h1);
         @(negedge clk);
         rst = 1'b0;
      end
      issue(32'h40C00000, 32'hC0000000);
      drain();

      for (int i = 0; i < 80; i++) begin
         hold_req = $urandom_range(0, 3);
         issue(rand_fp(), rand_fp());
      end
      drain();
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
